// File: rtl/doublecrack.sv
// Two-engine RC4 key cracker: even keys on c1, odd keys on c2; the first
// engine to verify a key has its decrypted message copied into local pt.
module crack #(
  parameter logic [23:0] KEY_START = 24'd0,
  parameter logic [23:0] KEY_STEP  = 24'd2
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        en_i,
  output logic        rdy_o,
  output logic [23:0] key_o,
  output logic        key_valid_o,
  input  logic        ct_we_i,
  input  logic [7:0]  ct_waddr_i,
  input  logic [7:0]  ct_wdata_i,
  input  logic [7:0]  pt_addr_i,
  output logic [7:0]  pt_rddata_o
);
  typedef enum logic [1:0] {C_IDLE, C_INIT, C_KSA, C_PRGA} cst_t;

  cst_t        st_q;
  logic        rdy_q, kv_q;
  logic [23:0] key_q;
  logic [7:0]  k_q, j_q, i_q, n_q, prd_q;
  logic [1:0]  m_q;
  logic [7:0]  s_q  [256];
  logic [7:0]  ct_q [256];
  logic [7:0]  pt_q [256];

  logic [7:0] kb, ksa_j, i1, si, jn, sj, t, ks, p;
  logic       printable, last_key;

  always_comb begin
    kb = (m_q == 2'd0) ? key_q[23:16] : (m_q == 2'd1) ? key_q[15:8] : key_q[7:0];
    ksa_j = j_q + s_q[k_q] + kb;
    i1 = i_q + 8'd1;
    si = s_q[i1];
    jn = j_q + si;
    sj = s_q[jn];
    t  = si + sj;
    // keystream byte is read from the post-swap permutation
    ks = (t == i1) ? sj : (t == jn) ? si : s_q[t];
    p  = ct_q[n_q] ^ ks;
    printable = (p >= 8'h20) && (p <= 8'h7e);
    last_key  = ({1'b0, key_q} + {1'b0, KEY_STEP}) > 25'h0ffffff;
  end

  always_ff @(posedge clk) begin
    if (ct_we_i) ct_q[ct_waddr_i] <= ct_wdata_i;
    prd_q <= pt_q[pt_addr_i];
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      st_q  <= C_IDLE;
      rdy_q <= 1'b1;
      kv_q  <= 1'b0;
      key_q <= KEY_START;
      k_q   <= '0;
      j_q   <= '0;
      i_q   <= '0;
      n_q   <= '0;
      m_q   <= '0;
    end else begin
      case (st_q)
        C_IDLE: if (en_i) begin
          rdy_q <= 1'b0;
          kv_q  <= 1'b0;
          key_q <= KEY_START;
          k_q   <= '0;
          st_q  <= C_INIT;
        end
        C_INIT: begin
          s_q[k_q] <= k_q;
          k_q <= k_q + 8'd1;
          if (k_q == 8'hff) begin
            j_q  <= '0;
            m_q  <= '0;
            st_q <= C_KSA;
          end
        end
        C_KSA: begin
          s_q[k_q]   <= s_q[ksa_j];
          s_q[ksa_j] <= s_q[k_q];
          j_q <= ksa_j;
          m_q <= (m_q == 2'd2) ? 2'd0 : m_q + 2'd1;
          k_q <= k_q + 8'd1;
          if (k_q == 8'hff) begin
            i_q <= '0;
            j_q <= '0;
            n_q <= 8'd1;
            pt_q[0] <= ct_q[0];
            if (ct_q[0] == 8'd0) begin
              kv_q  <= 1'b1;
              rdy_q <= 1'b1;
              st_q  <= C_IDLE;
            end else begin
              st_q <= C_PRGA;
            end
          end
        end
        C_PRGA: begin
          s_q[i1] <= sj;
          s_q[jn] <= si;
          i_q <= i1;
          j_q <= jn;
          pt_q[n_q] <= p;
          if (!printable) begin
            if (last_key) begin
              rdy_q <= 1'b1;
              st_q  <= C_IDLE;
            end else begin
              key_q <= key_q + KEY_STEP;
              k_q   <= '0;
              st_q  <= C_INIT;
            end
          end else if (n_q == ct_q[0]) begin
            kv_q  <= 1'b1;
            rdy_q <= 1'b1;
            st_q  <= C_IDLE;
          end else begin
            n_q <= n_q + 8'd1;
          end
        end
        default: st_q <= C_IDLE;
      endcase
    end
  end

  assign rdy_o       = rdy_q;
  assign key_o       = key_q;
  assign key_valid_o = kv_q;
  assign pt_rddata_o = prd_q;
endmodule

module doublecrack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  output logic [23:0] key,
  output logic        key_valid,
  output logic [7:0]  ct_addr,
  input  logic [7:0]  ct_rddata
);
  typedef enum logic [3:0] {
    D_IDLE, D_LOADCT, D_STARTC, D_CRACK, D_RDLEN1,
    D_RDLEN2, D_RDP, D_WRP, D_INCR, D_LOOP
  } dst_t;

  dst_t        st_q;
  logic        rdy_q, kv_q, ph_q, sel_q;
  logic [23:0] key_q;
  logic [8:0]  i_q;
  logic [7:0]  len_q;
  logic [7:0]  pt_q [256];

  logic        eng_rst, eng_en, ct_we;
  logic        rdy_1, rdy_2, kv_1, kv_2;
  logic [23:0] key_1, key_2;
  logic [7:0]  prd_1, prd_2, pt_src;

  assign eng_rst = rst_n || (st_q == D_IDLE);
  assign eng_en  = (st_q == D_STARTC);
  // each byte is held for two cycles so 1-cycle-latency memories also work
  assign ct_we   = (st_q == D_LOADCT) && ph_q;
  assign pt_src  = sel_q ? prd_2 : prd_1;

  crack #(.KEY_START(24'd0), .KEY_STEP(24'd2)) c1 (
    .clk(clk), .rst_i(eng_rst), .en_i(eng_en), .rdy_o(rdy_1), .key_o(key_1),
    .key_valid_o(kv_1), .ct_we_i(ct_we), .ct_waddr_i(i_q[7:0]),
    .ct_wdata_i(ct_rddata), .pt_addr_i(i_q[7:0]), .pt_rddata_o(prd_1)
  );

  crack #(.KEY_START(24'd1), .KEY_STEP(24'd2)) c2 (
    .clk(clk), .rst_i(eng_rst), .en_i(eng_en), .rdy_o(rdy_2), .key_o(key_2),
    .key_valid_o(kv_2), .ct_we_i(ct_we), .ct_waddr_i(i_q[7:0]),
    .ct_wdata_i(ct_rddata), .pt_addr_i(i_q[7:0]), .pt_rddata_o(prd_2)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      st_q  <= D_IDLE;
      rdy_q <= 1'b1;
      kv_q  <= 1'b0;
      key_q <= '0;
      i_q   <= '0;
      ph_q  <= 1'b0;
      sel_q <= 1'b0;
      len_q <= '0;
    end else begin
      case (st_q)
        D_IDLE: if (en) begin
          rdy_q <= 1'b0;
          kv_q  <= 1'b0;
          i_q   <= '0;
          ph_q  <= 1'b0;
          st_q  <= D_LOADCT;
        end
        D_LOADCT: begin
          ph_q <= ~ph_q;
          if (ph_q) begin
            i_q <= i_q + 9'd1;
            if (i_q[7:0] == 8'hff) begin
              i_q  <= '0;
              st_q <= D_STARTC;
            end
          end
        end
        D_STARTC: st_q <= D_CRACK;
        D_CRACK: begin
          if (rdy_1 && kv_1) begin
            key_q <= key_1;
            sel_q <= 1'b0;
            i_q   <= '0;
            st_q  <= D_RDLEN1;
          end else if (rdy_2 && kv_2) begin
            key_q <= key_2;
            sel_q <= 1'b1;
            i_q   <= '0;
            st_q  <= D_RDLEN1;
          end else if (rdy_1 && rdy_2) begin
            rdy_q <= 1'b1;
            st_q  <= D_IDLE;
          end
        end
        D_RDLEN1: st_q <= D_RDLEN2;
        D_RDLEN2: begin
          len_q   <= pt_src;
          pt_q[0] <= pt_src;
          kv_q    <= 1'b1;
          i_q     <= 9'd1;
          if (pt_src == 8'd0) begin
            rdy_q <= 1'b1;
            st_q  <= D_IDLE;
          end else begin
            st_q <= D_RDP;
          end
        end
        D_RDP: st_q <= D_WRP;
        D_WRP: begin
          pt_q[i_q[7:0]] <= pt_src;
          st_q <= D_INCR;
        end
        D_INCR: begin
          i_q  <= i_q + 9'd1;
          st_q <= D_LOOP;
        end
        D_LOOP: begin
          if (i_q <= {1'b0, len_q}) begin
            st_q <= D_RDP;
          end else begin
            rdy_q <= 1'b1;
            st_q  <= D_IDLE;
          end
        end
        default: st_q <= D_IDLE;
      endcase
    end
  end

  assign rdy       = rdy_q;
  assign key       = key_q;
  assign key_valid = kv_q;
  assign ct_addr   = i_q[7:0];
endmodule

// File: tb/tb_doublecrack.sv
// Bench for doublecrack: ciphertexts built from a reference RC4, results
// checked against a scoreboard of expected key / length / plaintext.
module tb_doublecrack;
  logic        clk = 1'b0;
  logic        rst_n, en, rdy, key_valid;
  logic [23:0] key;
  logic [7:0]  ct_addr, ct_rddata;

  logic [7:0] rom [256];
  logic [7:0] ptx [256];

  typedef struct packed {
    logic [23:0] key;
    logic        kv;
    logic [7:0]  len;
    logic [15:0] kvcyc;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] exp_pt [$];
  int errs = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) ct_rddata <= rom[ct_addr];

  doublecrack dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key),
    .key_valid(key_valid), .ct_addr(ct_addr), .ct_rddata(ct_rddata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    nchk++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // reference RC4: random printable plaintext of length L encrypted under k
  task automatic build(input logic [23:0] k, input int L);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] tmp, ii, jj;
    kb[0] = k[23:16]; kb[1] = k[15:8]; kb[2] = k[7:0];
    for (int n = 0; n < 256; n++) begin
      s[n]   = 8'(n);
      rom[n] = 8'($urandom_range(0, 255));
      ptx[n] = 8'($urandom_range(32, 126));
    end
    jj = 0;
    for (int n = 0; n < 256; n++) begin
      jj = jj + s[n] + kb[n % 3];
      tmp = s[n]; s[n] = s[jj]; s[jj] = tmp;
    end
    ii = 0; jj = 0;
    rom[0] = 8'(L);
    ptx[0] = 8'(L);
    for (int n = 1; n <= L; n++) begin
      ii = ii + 1;
      jj = jj + s[ii];
      tmp = s[ii]; s[ii] = s[jj]; s[jj] = tmp;
      tmp = s[ii] + s[jj];
      rom[n] = ptx[n] ^ s[tmp];
    end
  endtask

  task automatic start(input logic [23:0] ek, input int L);
    exp_t e;
    @(negedge clk); en = 1'b1;
    @(negedge clk);
    chk("start_rdy", 32'(rdy), 0);
    chk("start_kv", 32'(key_valid), 0);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("start_rdy2", 32'(rdy), 0);
    e.key = ek; e.kv = 1'b1; e.len = 8'(L); e.kvcyc = 16'(4 * L);
    exp_q.push_back(e);
    for (int n = 0; n <= L; n++) exp_pt.push_back(ptx[n]);
  endtask

  task automatic discard();
    exp_t e;
    e = exp_q.pop_front();
    for (int n = 0; n <= int'(e.len); n++) void'(exp_pt.pop_front());
  endtask

  task automatic finish_run();
    exp_t e;
    int cnt = 0;
    int cyc = 0;
    while (rdy !== 1'b1 && cnt < 20000) begin
      @(negedge clk);
      cnt++;
      if (key_valid === 1'b1 && rdy !== 1'b1) cyc++;
    end
    if (cnt >= 20000) begin
      chk("timeout", 0, 1);
      discard();
    end else begin
      e = exp_q.pop_front();
      chk("key", 32'(key), 32'(e.key));
      chk("key_valid", 32'(key_valid), 32'(e.kv));
      chk("copy_cycles", 32'(cyc), 32'(e.kvcyc));
      for (int n = 0; n <= int'(e.len); n++)
        chk($sformatf("pt[%0d]", n), 32'(dut.pt_q[n]), 32'(exp_pt.pop_front()));
    end
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    for (int n = 0; n < 256; n++) rom[n] = 8'h00;
    @(negedge clk);
    chk("rst_rdy", 32'(rdy), 1);
    chk("rst_kv", 32'(key_valid), 0);
    chk("rst_key", 32'(key), 0);
    chk("rst_addr", 32'(ct_addr), 0);
    rst_n = 1'b0;

    // key 0x000001 is c2's first candidate
    build(24'h000001, 8'h56);
    start(24'h000001, 8'h56);
    finish_run();

    // reset while engines are cracking, then restart on the same ciphertext
    start(24'h000001, 8'h56);
    repeat (700) @(negedge clk);
    chk("pre_rst_rdy", 32'(rdy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_rdy", 32'(rdy), 1);
    chk("mid_rst_kv", 32'(key_valid), 0);
    chk("mid_rst_key", 32'(key), 0);
    rst_n = 1'b0;
    discard();
    start(24'h000001, 8'h56);
    finish_run();

    // longest message; a stray en mid-run must be ignored
    build(24'h000001, 255);
    start(24'h000001, 255);
    repeat (100) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    finish_run();

    // empty message: both engines accept their first key together, c1 wins
    rom[0] = 8'h00;
    ptx[0] = 8'h00;
    start(24'h000000, 0);
    finish_run();

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
